// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the multicycle MIPS core control path.
//   state_t      : 3-bit sequencer state encoding, also used by the
//                  instruction register (latches while state == FETCH).
//   RESET_VECTOR : first PC value after reset, consumed by the PC block.
//   state_is_active : helper, 1 for states in which the CPU is running.
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [2:0] {
    RESET     = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXEC      = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    HALTED    = 3'd6
  } state_t;

  // Encoding 7 is never entered by design; it falls back to RESET.
  localparam logic [2:0] STATE_ILLEGAL = 3'd7;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

  function automatic logic state_is_active(input logic [2:0] s);
    return (s == FETCH) || (s == DECODE) || (s == EXEC) ||
           (s == MEM)   || (s == WRITEBACK);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// ---------------------------------------------------------------------------
// cpu_sequencer_if
// Avalon-style memory request bundle between the sequencer (master) and
// the memory side (slave).
//   mem_read        : read request
//   mem_write       : write request
//   mem_addr_sel    : 0 = address from PC, 1 = address from ALU result
//   mem_waitrequest : memory not ready, request must be held
// ---------------------------------------------------------------------------
interface cpu_sequencer_if;

  logic mem_read;
  logic mem_write;
  logic mem_addr_sel;
  logic mem_waitrequest;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr_sel,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr_sel,
    output mem_waitrequest
  );

endinterface

// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
// Multicycle control FSM for the MIPS core: FETCH, DECODE, EXEC, optional
// MEM, optional WRITEBACK, and the halt condition.
//
// Ports:
//   clk            : clock
//   reset          : synchronous, active-high reset
//   mem            : memory request bundle (cpu_sequencer_if.master)
//   is_mem_instr   : decoded instruction is a load/store
//   is_store       : decoded instruction is a store (valid with is_mem_instr)
//   is_writeback   : non-memory instruction writes the register file
//   halt_req       : next PC is zero, sampled at instruction completion
//   state          : current state encoding (see cpu_pkg::state_t)
//   pc_we          : PC update enable (EXEC only)
//   reg_we         : register-file write enable (WRITEBACK only)
//   active         : CPU running (not RESET, not HALTED)
//   stall_cycles   : waitrequest stall count, only with SEQ_STALL_COUNT_EN
//
// Build option:
//   SEQ_STALL_COUNT_EN : adds the saturating stall counter and its port,
//                        width set by parameter STALL_CNT_W.
//
// States:
//   RESET     | held in reset, no requests
//   FETCH     | instruction read from PC address, held on waitrequest
//   DECODE    | instruction decode, no requests
//   EXEC      | ALU operation, PC updated
//   MEM       | load/store at ALU address, held on waitrequest
//   WRITEBACK | register file write
//   HALTED    | next PC was zero; parked until reset
//   (7)       | illegal, all outputs low, returns to RESET
// ---------------------------------------------------------------------------
module cpu_sequencer
  import cpu_pkg::*;
`ifdef SEQ_STALL_COUNT_EN
#(
  parameter int STALL_CNT_W = 32
)
`endif
(
  input  logic                   clk,
  input  logic                   reset,
  cpu_sequencer_if.master        mem,
  input  logic                   is_mem_instr,
  input  logic                   is_store,
  input  logic                   is_writeback,
  input  logic                   halt_req,
  output logic [2:0]             state,
  output logic                   pc_we,
  output logic                   reg_we,
`ifdef SEQ_STALL_COUNT_EN
  output logic [STALL_CNT_W-1:0] stall_cycles,
`endif
  output logic                   active
);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       done_state;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= RESET;
    else       state_q <= state_d;
  end

  // Instruction completion target, shared by EXEC, MEM and WRITEBACK.
  assign done_state = halt_req;

  // Next state and Moore outputs
  always_comb begin
    state_d          = RESET;
    mem.mem_read     = 1'b0;
    mem.mem_write    = 1'b0;
    mem.mem_addr_sel = 1'b0;
    pc_we            = 1'b0;
    reg_we           = 1'b0;

    case (state_q)
      RESET: begin
        state_d = FETCH;
      end

      FETCH: begin
        mem.mem_read = 1'b1;
        state_d      = mem.mem_waitrequest ? FETCH : DECODE;
      end

      DECODE: begin
        state_d = EXEC;
      end

      EXEC: begin
        pc_we = 1'b1;
        if (is_mem_instr)      state_d = MEM;
        else if (is_writeback) state_d = WRITEBACK;
        else                   state_d = done_state ? HALTED : FETCH;
      end

      MEM: begin
        mem.mem_addr_sel = 1'b1;
        // Read and write are complementary on is_store, so never both high.
        mem.mem_read     = ~is_store;
        mem.mem_write    = is_store;
        if (mem.mem_waitrequest) state_d = MEM;
        else if (is_store)       state_d = done_state ? HALTED : FETCH;
        else                     state_d = WRITEBACK;
      end

      WRITEBACK: begin
        reg_we  = 1'b1;
        state_d = done_state ? HALTED : FETCH;
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = RESET;
      end
    endcase
  end

  assign state  = state_q;
  assign active = state_is_active(state_q);

`ifdef SEQ_STALL_COUNT_EN
  logic stall_now;

  assign stall_now = mem.mem_waitrequest &&
                     ((state_q == FETCH) || (state_q == MEM));

  // Saturating count; HALTED never matches stall_now so the value holds.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall_now && (stall_cycles != {STALL_CNT_W{1'b1}}))
      stall_cycles <= stall_cycles + 1'b1;
  end
`endif

endmodule
